// File: rtl/mismatch_event_counter.sv
// rtl/mismatch_event_counter.sv - synchronised rising-edge counter for the gated XOR mismatch flag
module mismatch_event_counter #(
    parameter int CNT_W        = 4,
    parameter int ALARM_THRESH = 8,
    parameter int HOLD_CYCLES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_in,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             pulse_out,
    output logic             alarm,
    output logic             sat,
    output logic             flag_sync
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  THRESH_M1 = CNT_W'(ALARM_THRESH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        ALARM    = 2'd2
    } state_t;

    logic              s1_q, s2_q, prev_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              alarm_q, alarm_d;
    logic              sat_q, sat_d;
    state_t            state_q, state_d;

    logic rise;
    logic reach;

    // Synchroniser and edge history are outside the clear domain on purpose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= flag_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise  = s2_q & ~prev_q;
    // True when this event brings the count to the alarm threshold or beyond.
    assign reach = (count_q >= THRESH_M1);

    always_comb begin
        count_d = count_q;
        hold_d  = hold_q;
        alarm_d = alarm_q;
        sat_d   = sat_q;
        state_d = state_q;

        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        if (clear) begin
            count_d = '0;
            hold_d  = '0;
            alarm_d = 1'b0;
            sat_d   = 1'b0;
            state_d = IDLE;
        end else if (rise) begin
            hold_d = HOLD_LOAD;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                sat_d = 1'b1;
            end
            if (reach) begin
                alarm_d = 1'b1;
            end
            case (state_q)
                IDLE:     state_d = reach ? ALARM : COUNTING;
                COUNTING: if (reach) state_d = ALARM;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            hold_q  <= '0;
            alarm_q <= 1'b0;
            sat_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            hold_q  <= hold_d;
            alarm_q <= alarm_d;
            sat_q   <= sat_d;
            state_q <= state_d;
        end
    end

    assign count     = count_q;
    assign pulse_out = (hold_q != '0);
    assign alarm     = alarm_q;
    assign sat       = sat_q;
    assign flag_sync = s2_q;

endmodule

// File: tb/tb_mismatch_event_counter.sv
// tb/tb_mismatch_event_counter.sv - directed bench for mismatch_event_counter
module tb_mismatch_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_in;
    logic       clear;
    logic [3:0] count;
    logic       pulse_out;
    logic       alarm;
    logic       sat;
    logic       flag_sync;

    int checks = 0;
    int errors = 0;

    mismatch_event_counter #(
        .CNT_W(4),
        .ALARM_THRESH(8),
        .HOLD_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flag_in(flag_in),
        .clear(clear),
        .count(count),
        .pulse_out(pulse_out),
        .alarm(alarm),
        .sat(sat),
        .flag_sync(flag_sync)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; flag_in = 1'b0;
        cyc(3);
        checks++;
        if ({count, pulse_out, alarm, sat, flag_sync} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got count=%0d pulse=%b alarm=%b sat=%b sync=%b want all 0",
                     count, pulse_out, alarm, sat, flag_sync);
        end
        rst = 1'b0;
        cyc(2);
        checks++;
        if ({count, pulse_out, alarm, sat} !== 7'h00) begin
            errors++;
            $display("FAIL after_release got count=%0d pulse=%b alarm=%b sat=%b want all 0",
                     count, pulse_out, alarm, sat);
        end
    endtask

    task automatic test_single_event();
        logic exp_pulse;
        logic [3:0] exp_count;
        flag_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            if (k == 5) flag_in = 1'b0;
            exp_count = (k >= 3) ? 4'd1 : 4'd0;
            exp_pulse = (k >= 3 && k <= 5);
            checks++;
            if (count !== exp_count || pulse_out !== exp_pulse) begin
                errors++;
                $display("FAIL single_event k=%0d got count=%0d pulse=%b want count=%0d pulse=%b",
                         k, count, pulse_out, exp_count, exp_pulse);
            end
            if (k == 2) begin
                checks++;
                if (flag_sync !== 1'b1) begin
                    errors++;
                    $display("FAIL flag_sync_latency got %b want 1", flag_sync);
                end
            end
        end
        cyc(3);
        checks++;
        if (count !== 4'd1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL single_event_final got count=%0d alarm=%b want 1 0", count, alarm);
        end
    endtask

    task automatic test_alarm();
        do_clear();
        for (int i = 1; i <= 8; i++) begin
            flag_in = 1'b1;
            cyc(2);
            checks++;
            if (count !== 4'(i - 1) || alarm !== (i - 1 >= 8)) begin
                errors++;
                $display("FAIL alarm_pre i=%0d got count=%0d alarm=%b want %0d %b",
                         i, count, alarm, i - 1, (i - 1 >= 8));
            end
            flag_in = 1'b0;
            cyc(1);
            checks++;
            if (count !== 4'(i) || alarm !== (i >= 8) || sat !== 1'b0) begin
                errors++;
                $display("FAIL alarm_post i=%0d got count=%0d alarm=%b sat=%b want %0d %b 0",
                         i, count, alarm, sat, i, (i >= 8));
            end
            cyc(2);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_count;
        do_clear();
        for (int i = 1; i <= 17; i++) begin
            flag_in = 1'b1;
            cyc(2);
            flag_in = 1'b0;
            cyc(1);
            exp_count = (i >= 15) ? 4'd15 : 4'(i);
            checks++;
            if (count !== exp_count || sat !== (i >= 16) || alarm !== (i >= 8)) begin
                errors++;
                $display("FAIL saturate i=%0d got count=%0d sat=%b alarm=%b want %0d %b %b",
                         i, count, sat, alarm, exp_count, (i >= 16), (i >= 8));
            end
            cyc(2);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_pulse;
        do_clear();
        for (int k = 0; k <= 9; k++) begin
            flag_in = (k == 0 || k == 2);
            cyc(1);
            exp_pulse = (k + 1 >= 3 && k + 1 <= 7);
            checks++;
            if (pulse_out !== exp_pulse) begin
                errors++;
                $display("FAIL retrigger k=%0d got pulse=%b want %b", k + 1, pulse_out, exp_pulse);
            end
        end
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL retrigger_count got %0d want 2", count);
        end
    endtask

    task automatic test_clear_collision();
        do_clear();
        for (int i = 0; i < 5; i++) begin
            flag_in = 1'b1; cyc(2);
            flag_in = 1'b0; cyc(3);
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL collision_setup got count=%0d want 5", count);
        end
        flag_in = 1'b1;
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        checks++;
        if (count !== 4'd0 || alarm !== 1'b0 || pulse_out !== 1'b0 || dut.state_q !== 2'd0) begin
            errors++;
            $display("FAIL collision got count=%0d alarm=%b pulse=%b state=%0d want 0 0 0 0",
                     count, alarm, pulse_out, dut.state_q);
        end
        flag_in = 1'b0;
        cyc(4);
        flag_in = 1'b1; cyc(2);
        flag_in = 1'b0; cyc(3);
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL collision_next got count=%0d want 1", count);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            flag_in = 1'b1; cyc(2);
            flag_in = 1'b0; cyc(3);
        end
        flag_in = 1'b1;
        cyc(3);
        checks++;
        if (count !== 4'd9 || pulse_out !== 1'b1 || alarm !== 1'b1) begin
            errors++;
            $display("FAIL midpulse_setup got count=%0d pulse=%b alarm=%b want 9 1 1",
                     count, pulse_out, alarm);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({count, pulse_out, alarm, sat, flag_sync} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got count=%0d pulse=%b alarm=%b sat=%b sync=%b want all 0",
                     count, pulse_out, alarm, sat, flag_sync);
        end
        cyc(2);
        rst = 1'b0;
        cyc(3);
        checks++;
        if (count !== 4'd1 || pulse_out !== 1'b1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_event got count=%0d pulse=%b alarm=%b want 1 1 0",
                     count, pulse_out, alarm);
        end
        flag_in = 1'b0;
        cyc(5);
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_hold got count=%0d want 1", count);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        flag_in = 1'b0;
        test_reset();
        test_single_event();
        test_alarm();
        test_saturate();
        test_back_to_back();
        test_clear_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
